// File: rtl/dff_arb_pkg.sv
// dff_arb_pkg: shared types and helpers for the round-robin write arbiter.
//   state_e  - arbiter FSM states (idle, grant, commit)
//   StateW   - width of the state encoding
//   MaxReq   - largest supported requester count
//   rr_pick  - round-robin winner search starting at a pointer
package dff_arb_pkg;

  localparam int unsigned StateW = 2;
  localparam int unsigned MaxReq = 8;
  localparam int unsigned IdxW   = 3;

  typedef enum logic [StateW-1:0] {
    StIdle   = 2'd0,
    StGrant  = 2'd1,
    StCommit = 2'd2
  } state_e;

  // First set bit of req at or above ptr, wrapping modulo n. Returns ptr when req is empty;
  // callers only use the result when at least one request is pending.
  function automatic int unsigned rr_pick(input logic [MaxReq-1:0] req,
                                          input int unsigned       ptr,
                                          input int unsigned       n);
    logic            found;
    logic [IdxW-1:0] idx;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      idx = IdxW'((ptr + k) % n);
      if (!found && (k < n) && req[idx]) begin
        rr_pick = 32'(idx);
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/dff_reg.sv
// dff_reg: WIDTH-bit D register with load enable and complementary outputs.
//   clk_i  - rising-edge clock
//   rst_ni - synchronous active-low reset, clears q
//   en_i   - load d_i on the next rising edge
//   d_i    - data to load
//   q_o    - register value
//   qbar_o - bitwise complement of q_o
module dff_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qbar_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o    = q_q;
  assign qbar_o = ~q_q;

endmodule

// File: rtl/dff_write_arbiter.sv
// dff_write_arbiter: round-robin arbiter sharing one WIDTH-bit register among N_REQ writers.
// Each write takes IDLE -> GRANT -> COMMIT; the granted word lands in the register on the
// GRANT -> COMMIT edge and done pulses during COMMIT.
// Optional feature macro: DFF_ARB_LOCK_EN adds lock_i, letting the current owner chain
// writes (COMMIT -> GRANT) while lock and req stay high.
//   clk_i   - rising-edge clock
//   rst_ni  - synchronous active-low reset; aborts any write in flight
//   req_i   - per-requester level request, held until done
//   din_i   - requester i data at [i*WIDTH +: WIDTH]
//   lock_i  - per-requester grant hold (DFF_ARB_LOCK_EN only)
//   gnt_o   - one-hot grant during GRANT
//   done_o  - one-hot completion pulse during COMMIT
//   q_o     - shared register value, qbar_o its complement
//   busy_o  - high in GRANT and COMMIT
//   owner_o - current or last granted requester
module dff_write_arbiter
  import dff_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned OwnerW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] din_i,
`ifdef DFF_ARB_LOCK_EN
  input  logic [N_REQ-1:0]       lock_i,
`endif
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic [WIDTH-1:0]       q_o,
  output logic [WIDTH-1:0]       qbar_o,
  output logic                   busy_o,
  output logic [OwnerW-1:0]      owner_o
);

  state_e            state_q;
  logic [OwnerW-1:0] ptr_q;
  logic [OwnerW-1:0] owner_q;
  logic [OwnerW-1:0] ptr_inc;
  logic [MaxReq-1:0] req_pad;
  logic [WIDTH-1:0]  wr_data;

  always_comb begin
    req_pad              = '0;
    req_pad[N_REQ-1:0]   = req_i;
  end

  // Pointer moves one past the owner so the owner loses ties on its next request.
  always_comb begin
    if (owner_q == OwnerW'(N_REQ - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = owner_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req_i) begin
            owner_q <= OwnerW'(rr_pick(req_pad, 32'(ptr_q), N_REQ));
            state_q <= StGrant;
          end
        end
        StGrant: begin
          state_q <= StCommit;
        end
        StCommit: begin
`ifdef DFF_ARB_LOCK_EN
          if (lock_i[owner_q] && req_i[owner_q]) begin
            state_q <= StGrant;
          end else begin
            ptr_q   <= ptr_inc;
            state_q <= StIdle;
          end
`else
          ptr_q   <= ptr_inc;
          state_q <= StIdle;
`endif
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Grant/done are decoded from registered state and owner only; no path from req_i.
  always_comb begin
    gnt_o  = '0;
    done_o = '0;
    if (state_q == StGrant) begin
      gnt_o[owner_q] = 1'b1;
    end
    if (state_q == StCommit) begin
      done_o[owner_q] = 1'b1;
    end
  end

  assign busy_o  = (state_q != StIdle);
  assign owner_o = owner_q;
  assign wr_data = din_i[owner_q*WIDTH +: WIDTH];

  dff_reg #(
    .WIDTH (WIDTH)
  ) u_dff_reg (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (state_q == StGrant),
    .d_i    (wr_data),
    .q_o    (q_o),
    .qbar_o (qbar_o)
  );

endmodule

// File: tb/tb_dff_write_arbiter.sv
// tb_dff_write_arbiter: directed stimulus with a done/q scoreboard for dff_write_arbiter.
module tb_dff_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  q;
  logic [7:0]  qbar;
  logic        busy;
  logic [1:0]  owner;
`ifdef DFF_ARB_LOCK_EN
  logic [3:0]  lock;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] done;
    logic [7:0] q;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  dff_write_arbiter #(
    .N_REQ (4),
    .WIDTH (8)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .din_i   (din),
`ifdef DFF_ARB_LOCK_EN
    .lock_i  (lock),
`endif
    .gnt_o   (gnt),
    .done_o  (done),
    .q_o     (q),
    .qbar_o  (qbar),
    .busy_o  (busy),
    .owner_o (owner)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] nq;
    if (done !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'h0);
      end else begin
        e  = exp_q.pop_front();
        nq = ~e.q;
        check("done", 32'(done), 32'(e.done));
        check("q", 32'(q), 32'(e.q));
        check("qbar", 32'(qbar), 32'(nq));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    din   = '0;
`ifdef DFF_ARB_LOCK_EN
    lock  = '0;
`endif
    // Reset
    tick();
    tick();
    check("rst_q", 32'(q), 32'h00);
    check("rst_qbar", 32'(qbar), 32'hFF);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);

    // Single request from requester 2
    rst_n = 1'b1;
    req   = 4'b0100;
    din   = 32'h00A5_0000;
    exp_q.push_back({4'b0100, 8'hA5});
    tick();
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_owner", 32'(owner), 32'h2);
    tick();
    req = '0;
    tick();
    check("single_busy_end", 32'(busy), 32'h0);
    check("single_q_hold", 32'(q), 32'hA5);

    // Skip and wrap: pointer now 3, requesters 0 and 1 pending
    req = 4'b0011;
    din = 32'h0000_3130;
    exp_q.push_back({4'b0001, 8'h30});
    exp_q.push_back({4'b0010, 8'h31});
    tick();
    check("wrap_gnt0", 32'(gnt), 32'h1);
    tick();
    tick();
    check("wrap_idle_gnt", 32'(gnt), 32'h0);
    tick();
    check("wrap_gnt1", 32'(gnt), 32'h2);
    tick();
    req = '0;
    tick();
    check("wrap_busy_end", 32'(busy), 32'h0);

    // Abort: reset while granted, no done and q cleared
    req = 4'b1000;
    din = 32'h7700_0000;
    tick();
    check("abort_gnt", 32'(gnt), 32'h8);
    rst_n = 1'b0;
    tick();
    check("abort_q", 32'(q), 32'h00);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    req = '0;
    tick();
    rst_n = 1'b1;

    // Rotation: all four requesting, pointer starts at 0 after reset
    req = 4'b1111;
    din = 32'h1312_1110;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back({4'(1 << (k % 4)), 8'(8'h10 + (k % 4))});
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rot_gnt", 32'(gnt), 32'(1 << (k % 4)));
      tick();
      if (k == 4) req = '0;
      tick();
      check("rot_idle", 32'(busy), 32'h0);
    end

`ifdef DFF_ARB_LOCK_EN
    // Lock: pointer is 1, requester 1 chains three writes, then requester 0 wins
    req  = 4'b0011;
    lock = 4'b0010;
    din  = 32'h0000_4150;
    exp_q.push_back({4'b0010, 8'h41});
    exp_q.push_back({4'b0010, 8'h42});
    exp_q.push_back({4'b0010, 8'h43});
    exp_q.push_back({4'b0001, 8'h50});
    tick();
    check("lock_gnt_a", 32'(gnt), 32'h2);
    tick();
    din[15:8] = 8'h42;
    tick();
    check("lock_gnt_b", 32'(gnt), 32'h2);
    tick();
    din[15:8] = 8'h43;
    tick();
    check("lock_gnt_c", 32'(gnt), 32'h2);
    tick();
    lock = '0;
    req  = 4'b0001;
    tick();
    check("lock_release_idle", 32'(busy), 32'h0);
    tick();
    check("lock_gnt_next", 32'(gnt), 32'h1);
    tick();
    req = '0;
    tick();
`endif

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_write_arbiter.md
# dff_write_arbiter

Round-robin write arbiter sharing one WIDTH-bit D register (q/qbar pair) between N_REQ requesters. Each requester raises a request with its data word. The arbiter grants one requester at a time, commits the granted word into the shared register, and pulses a per-requester completion. It sits between producer blocks and the shared state register they would otherwise drive directly.

## Interface
- N_REQ, 4, number of requesters (1..8)
- WIDTH, 8, data and register width
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous, active-low
- req  input  N_REQ  per-requester write request; level, held until done
- din  input  N_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- lock  input  N_REQ  keep grant for back-to-back writes (present only with DFF_ARB_LOCK_EN)
- gnt  output  N_REQ  one-hot grant; asserted for exactly the GRANT cycle
- done  output  N_REQ  one-hot, one-cycle pulse in the COMMIT cycle
- q  output  WIDTH  shared register value
- qbar  output  WIDTH  always bitwise ~q
- busy  output  1  high in GRANT and COMMIT
- owner  output  max(1,$clog2(N_REQ))  index of current or last granted requester

## Operation
- FSM states: IDLE, GRANT, COMMIT.
- IDLE: if any req bit is high, select the winner and go to GRANT; else stay.
- Winner: first set req bit searching upward from pointer ptr, wrapping modulo N_REQ.
- GRANT: gnt[owner]=1. din slice of owner is written into q at the edge leaving GRANT. Next state is COMMIT.
- COMMIT: done[owner]=1. ptr <= owner+1 (mod N_REQ). Next state is IDLE.
- Data is captured at grant. Dropping req during GRANT or COMMIT does not cancel the write.
- Requests arriving while busy wait. They are evaluated in the next IDLE.
- A requester that holds req continuously after done is re-arbitrated normally and loses to others in rotation.
- Reset values: state IDLE, ptr 0, q 0, qbar all ones, gnt 0, done 0, busy 0, owner 0.
- Reset mid-transaction aborts it. q is cleared and no done is issued.
- q changes only on the GRANT->COMMIT edge or on reset.

## Timing
- req sampled in IDLE at cycle t -> gnt high in t+1 -> q updated and done high in t+2 -> IDLE in t+3.
- Peak throughput: one write every 3 cycles.
- Outputs are registered or decoded from the state register only. There is no combinational path from req to gnt.
- With N_REQ=1, ptr stays 0 and behaviour is identical apart from arbitration.

## Configuration
- DFF_ARB_LOCK_EN defined:
  - lock port exists.
  - In COMMIT, if lock[owner] && req[owner], next state is GRANT for the same owner. IDLE is skipped and ptr is not advanced.
  - Locked throughput is one write every 2 cycles.
  - Lock is released when lock or req drops in a COMMIT cycle. ptr then advances as normal.
- DFF_ARB_LOCK_EN undefined: lock port absent; COMMIT always goes to IDLE.

## Structure
- Package dff_arb_pkg holds:
  - state enum (IDLE, GRANT, COMMIT)
  - state width localparam
  - round-robin pick function (req vector, ptr -> index)
- Sub-module dff_reg: WIDTH-bit D register with enable, synchronous active-low reset, and q/qbar outputs.
- The arbiter instantiates one dff_reg, enabled in GRANT.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> q=8'h00, qbar=8'hFF, gnt=0, done=0, busy=0.
- Single request, N_REQ=4: req=4'b0100, din[2]=8'hA5 at t -> gnt=4'b0100 at t+1; q=8'hA5, qbar=8'h5A, done=4'b0100 at t+2; busy=0 at t+3.
- Rotation: req=4'b1111 held, din[i]=8'h10+i -> grants in order 0,1,2,3,0, each 3 cycles apart; q follows 8'h10, 8'h11, 8'h12, 8'h13.
- Skip and wrap: ptr=3 after a grant to 2, req=4'b0011 -> grant 0 then 1; requester 3 is never granted.
- Abort: rst_n=0 in the cycle gnt is high -> no done pulse, q=0, state IDLE.
- Lock (macro defined): req[1]=1, lock[1]=1 for 3 writes with req[0]=1 pending -> three grants to 1 at 2-cycle spacing, then grant 0 after lock drops.
